instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Responder side of the control unit's fetch request. Owns the program counter.
//  Reads the opcode and up to two operand bytes from program ROM over a rd/ack handshake.
//  Presents the bytes to the decoder and signals completion to the control unit.
//  Sits between the control unit FSM, the instruction decoder and program memory.
// PARAMETERS
//  ADDR_W    16      program counter / ROM address width
//  RESET_PC  16'h0   PC value after reset
// PORTS
//  clock        in   1       system clock, all logic on rising edge
//  reset        in   1       synchronous, active-low (reset==0 resets)
//  fetch        in   1       fetch request from control unit, sampled in IDLE only
//  pc_load      in   1       load PC from pc_new, honoured in IDLE only
//  pc_new       in   ADDR_W  branch/jump target
//  len_valid    in   1       decoder has supplied instr_len
//  instr_len    in   2       instruction length in bytes: 1,2,3 (0 treated as 1)
//  rom_rd       out  1       one-cycle ROM read strobe
//  rom_addr     out  ADDR_W  ROM address, valid while rom_rd=1
//  rom_data     in   8       ROM read data, valid when rom_ack=1
//  rom_ack      in   1       ROM data valid, >=1 cycle after rom_rd
//  opcode       out  8       fetched opcode, held until next fetch
//  operand1     out  8       second instruction byte (0 if absent)
//  operand2     out  8       third instruction byte (0 if absent)
//  opcode_valid out  1       1-cycle pulse: opcode register updated
//  fetch_done   out  1       1-cycle pulse: whole instruction fetched
//  busy         out  1       high in every state except IDLE
//  pc           out  ADDR_W  current PC (address of next byte to fetch)
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, rom_addr=RESET_PC.
//   All other outputs 0. Byte counter cleared.
//  States: IDLE, RD_OP, WAIT_OP, LEN, RD_OPR, WAIT_OPR, DONE. All outputs registered.
//  IDLE: pc_load=1 -> pc<=pc_new.
//   fetch=1 -> clear operand1/2, state RD_OP. Read uses pc_new if pc_load is also high.
//  RD_OP: rom_rd=1, rom_addr=pc for exactly one cycle -> WAIT_OP.
//  WAIT_OP: on rom_ack: opcode<=rom_data, pc<=pc+1 -> LEN.
//  LEN: opcode_valid=1 in its first cycle only. Waits for len_valid; len_valid may coincide with that first cycle.
//   Effective len 1 -> DONE. Len 2/3 -> RD_OPR, bytes_left=len-1.
//  RD_OPR: rom_rd=1, rom_addr=pc for one cycle -> WAIT_OPR.
//  WAIT_OPR: on rom_ack: store byte (first->operand1, second->operand2), pc<=pc+1, bytes_left-1.
//   bytes_left was 1 -> DONE, else -> RD_OPR.
//  DONE: fetch_done=1 for one cycle -> IDLE.
//  Min latency, ROM ack 1 cycle after rd, len_valid with opcode_valid:
//   fetch sampled at edge 0 -> fetch_done high in cycle 4 (1 byte), 6 (2 bytes), 8 (3 bytes).
//  PC arithmetic modulo 2^ADDR_W: all-ones + 1 wraps to 0. Wrap may occur mid-instruction.
//  Ignored conditions:
//   fetch or pc_load while busy (no queueing).
//   rom_ack outside WAIT_OP/WAIT_OPR.
//   len_valid outside LEN.
//  rom_rd is never reasserted before the matching rom_ack; at most one ROM read outstanding.
//  Reset mid-operation: immediate return to reset values. A late rom_ack after reset is ignored.
// TESTING
//  T1 reset=0 for 2 cycles, then 1 -> pc=0, busy=0, rom_rd=0, all outputs 0.
//  T2 ROM[0]=0x04, len=1 -> opcode=0x04, operands=0, fetch_done in cycle 4, pc=1.
//  T3 ROM[0..2]=0x02,0x12,0x34, len=3 -> opcode=0x02, op1=0x12, op2=0x34, done cycle 8, pc=3.
//  T4 pc_load=1 with pc_new=0xFFFF and fetch=1 together, ROM[FFFF]=0x74, ROM[0]=0x55, len=2
//     -> rom_addr 0xFFFF then 0x0000, op1=0x55, pc=0x0001.
//  T5 ROM ack latency 3 cycles and fetch/pc_load pulsed while busy -> no extra rom_rd, pc unaffected.
//  T6 reset=0 while in WAIT_OPR, then stray rom_ack -> state IDLE, pc=RESET_PC, no fetch_done.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC and reads opcode plus up to
// two operand bytes from program ROM over a rd/ack handshake.
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_new,
  input  logic              len_valid,
  input  logic [1:0]        instr_len,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              rom_ack,
  output logic [7:0]        opcode,
  output logic [7:0]        operand1,
  output logic [7:0]        operand2,
  output logic              opcode_valid,
  output logic              fetch_done,
  output logic              busy,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [2:0] {
    IDLE,
    RD_OP,
    WAIT_OP,
    LEN,
    RD_OPR,
    WAIT_OPR,
    DONE
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic              rom_rd_d;
  logic [ADDR_W-1:0] rom_addr_d;
  logic [7:0]        opcode_d;
  logic [7:0]        operand1_d;
  logic [7:0]        operand2_d;
  logic              opcode_valid_d;
  logic              fetch_done_d;
  logic              busy_d;
  logic [1:0]        bytes_left, bytes_left_d;
  logic              opr_sel, opr_sel_d;
  logic [1:0]        eff_len;

  assign pc_inc  = pc + ADDR_W'(1);
  assign eff_len = (instr_len == 2'd0) ? 2'd1 : instr_len;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      rom_rd       <= 1'b0;
      rom_addr     <= RESET_PC;
      opcode       <= 8'h00;
      operand1     <= 8'h00;
      operand2     <= 8'h00;
      opcode_valid <= 1'b0;
      fetch_done   <= 1'b0;
      busy         <= 1'b0;
      bytes_left   <= 2'd0;
      opr_sel      <= 1'b0;
    end else begin
      state        <= state_d;
      pc           <= pc_d;
      rom_rd       <= rom_rd_d;
      rom_addr     <= rom_addr_d;
      opcode       <= opcode_d;
      operand1     <= operand1_d;
      operand2     <= operand2_d;
      opcode_valid <= opcode_valid_d;
      fetch_done   <= fetch_done_d;
      busy         <= busy_d;
      bytes_left   <= bytes_left_d;
      opr_sel      <= opr_sel_d;
    end
  end

  // Outputs are registered: each branch sets the values seen next cycle.
  always_comb begin
    state_d        = state;
    pc_d           = pc;
    rom_rd_d       = 1'b0;
    rom_addr_d     = rom_addr;
    opcode_d       = opcode;
    operand1_d     = operand1;
    operand2_d     = operand2;
    opcode_valid_d = 1'b0;
    fetch_done_d   = 1'b0;
    bytes_left_d   = bytes_left;
    opr_sel_d      = opr_sel;
    unique case (state)
      IDLE: begin
        if (pc_load) pc_d = pc_new;
        if (fetch) begin
          operand1_d = 8'h00;
          operand2_d = 8'h00;
          rom_rd_d   = 1'b1;
          rom_addr_d = pc_load ? pc_new : pc;
          state_d    = RD_OP;
        end
      end
      RD_OP: state_d = WAIT_OP;
      WAIT_OP: begin
        if (rom_ack) begin
          opcode_d       = rom_data;
          pc_d           = pc_inc;
          opcode_valid_d = 1'b1;
          state_d        = LEN;
        end
      end
      LEN: begin
        if (len_valid) begin
          if (eff_len == 2'd1) begin
            fetch_done_d = 1'b1;
            state_d      = DONE;
          end else begin
            rom_rd_d     = 1'b1;
            rom_addr_d   = pc;
            bytes_left_d = eff_len - 2'd1;
            opr_sel_d    = 1'b0;
            state_d      = RD_OPR;
          end
        end
      end
      RD_OPR: state_d = WAIT_OPR;
      WAIT_OPR: begin
        if (rom_ack) begin
          if (opr_sel) operand2_d = rom_data;
          else         operand1_d = rom_data;
          opr_sel_d    = 1'b1;
          pc_d         = pc_inc;
          bytes_left_d = bytes_left - 2'd1;
          if (bytes_left == 2'd1) begin
            fetch_done_d = 1'b1;
            state_d      = DONE;
          end else begin
            rom_rd_d   = 1'b1;
            rom_addr_d = pc_inc;
            state_d    = RD_OPR;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a latency-configurable
// ROM responder and a decoder model that answers opcode_valid.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fetch = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_new = 16'h0;
  logic        len_valid = 1'b0;
  logic [1:0]  instr_len = 2'd0;
  logic        rom_rd;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;
  logic        rom_ack = 1'b0;
  logic [7:0]  opcode, operand1, operand2;
  logic        opcode_valid, fetch_done, busy;
  logic [15:0] pc;

  instruction_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0)) dut (
    .clock(clock), .reset(reset), .fetch(fetch),
    .pc_load(pc_load), .pc_new(pc_new),
    .len_valid(len_valid), .instr_len(instr_len),
    .rom_rd(rom_rd), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ack(rom_ack),
    .opcode(opcode), .operand1(operand1), .operand2(operand2),
    .opcode_valid(opcode_valid), .fetch_done(fetch_done),
    .busy(busy), .pc(pc)
  );

  always #5 clock = ~clock;

  logic [7:0]  rom [0:65535];
  logic [15:0] addr_q[$];
  int          checks = 0;
  int          failures = 0;
  int          lat = 1;
  int          cur_len = 1;
  int          rd_cnt = 0;
  int          ov_cnt = 0;
  int          fd_cnt = 0;
  int          viol = 0;

  // ROM responder and monitor, evaluated mid-cycle
  initial begin : responder
    bit          pend;
    int          cnt;
    logic [15:0] a;
    pend = 0;
    cnt = 0;
    a = 16'h0;
    forever begin
      @(negedge clock);
      rom_ack = 1'b0;
      if (opcode_valid === 1'b1) ov_cnt++;
      if (fetch_done === 1'b1) fd_cnt++;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          rom_ack = 1'b1;
          rom_data = rom[a];
          pend = 0;
        end
      end
      if (rom_rd === 1'b1) begin
        if (pend) viol++;
        rd_cnt++;
        addr_q.push_back(rom_addr);
        a = rom_addr;
        cnt = lat;
        pend = 1;
      end
    end
  end

  initial begin : decoder
    forever begin
      @(negedge clock);
      len_valid = (opcode_valid === 1'b1);
      instr_len = 2'(cur_len);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns the cycle (1 = first cycle after the fetch edge) of fetch_done
  task automatic run_fetch(input bit ld, input logic [15:0] tgt,
                           input int poke, output int done_c);
    fetch = 1'b1;
    pc_load = ld;
    pc_new = tgt;
    tick();
    fetch = 1'b0;
    pc_load = 1'b0;
    done_c = -1;
    for (int c = 1; c <= 40; c++) begin
      if (fetch_done === 1'b1) begin
        done_c = c;
        break;
      end
      if (c == poke) begin
        fetch = 1'b1;
        pc_load = 1'b1;
        pc_new = 16'h1234;
      end else begin
        fetch = 1'b0;
        pc_load = 1'b0;
      end
      tick();
    end
    fetch = 1'b0;
    pc_load = 1'b0;
  endtask

  initial begin : main
    int dc;
    int rd0, fd0, ov0;
    for (int i = 0; i < 65536; i++) rom[i] = 8'h00;

    // T1 reset
    reset = 1'b0;
    tick();
    tick();
    chk("t1_pc", 32'(pc), 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);
    chk("t1_rom_rd", 32'(rom_rd), 32'h0);
    chk("t1_rom_addr", 32'(rom_addr), 32'h0);
    chk("t1_opcode", 32'(opcode), 32'h0);
    chk("t1_ops", {16'h0, operand1, operand2}, 32'h0);
    chk("t1_pulses", {30'h0, opcode_valid, fetch_done}, 32'h0);
    reset = 1'b1;
    tick();

    // T2 one-byte instruction
    rom[0] = 8'h04;
    cur_len = 1;
    addr_q.delete();
    run_fetch(0, 16'h0, 0, dc);
    chk("t2_done_cycle", 32'(dc), 32'd4);
    chk("t2_opcode", 32'(opcode), 32'h04);
    chk("t2_ops", {16'h0, operand1, operand2}, 32'h0);
    chk("t2_pc", 32'(pc), 32'h1);
    chk("t2_rd_cnt", 32'(rd_cnt), 32'd1);
    chk("t2_ov_cnt", 32'(ov_cnt), 32'd1);
    tick();
    chk("t2_busy_after", 32'(busy), 32'h0);
    chk("t2_fd_pulse", 32'(fetch_done), 32'h0);

    // pc_load alone in IDLE
    pc_load = 1'b1;
    pc_new = 16'h0;
    tick();
    pc_load = 1'b0;
    chk("pcload_pc", 32'(pc), 32'h0);
    chk("pcload_busy", 32'(busy), 32'h0);

    // T3 three-byte instruction
    rom[0] = 8'h02;
    rom[1] = 8'h12;
    rom[2] = 8'h34;
    cur_len = 3;
    addr_q.delete();
    run_fetch(0, 16'h0, 0, dc);
    chk("t3_done_cycle", 32'(dc), 32'd8);
    chk("t3_opcode", 32'(opcode), 32'h02);
    chk("t3_op1", 32'(operand1), 32'h12);
    chk("t3_op2", 32'(operand2), 32'h34);
    chk("t3_pc", 32'(pc), 32'h3);
    chk("t3_nrd", 32'(addr_q.size()), 32'd3);
    if (addr_q.size() == 3) chk("t3_addr2", 32'(addr_q[2]), 32'h2);
    tick();

    // T4 load+fetch with PC wrap mid-instruction
    rom[16'hFFFF] = 8'h74;
    rom[0] = 8'h55;
    cur_len = 2;
    addr_q.delete();
    run_fetch(1, 16'hFFFF, 0, dc);
    chk("t4_done_cycle", 32'(dc), 32'd6);
    chk("t4_nrd", 32'(addr_q.size()), 32'd2);
    if (addr_q.size() == 2) begin
      chk("t4_addr0", 32'(addr_q[0]), 32'hFFFF);
      chk("t4_addr1", 32'(addr_q[1]), 32'h0000);
    end
    chk("t4_opcode", 32'(opcode), 32'h74);
    chk("t4_op1", 32'(operand1), 32'h55);
    chk("t4_op2", 32'(operand2), 32'h00);
    chk("t4_pc", 32'(pc), 32'h0001);
    tick();

    // T5 slow ROM, fetch/pc_load pulsed while busy
    rom[1] = 8'h11;
    rom[2] = 8'h22;
    lat = 3;
    cur_len = 2;
    rd0 = rd_cnt;
    run_fetch(0, 16'h0, 2, dc);
    chk("t5_done_cycle", 32'(dc), 32'd10);
    chk("t5_opcode", 32'(opcode), 32'h11);
    chk("t5_op1", 32'(operand1), 32'h22);
    chk("t5_pc", 32'(pc), 32'h3);
    repeat (4) tick();
    chk("t5_rd_delta", 32'(rd_cnt - rd0), 32'd2);
    chk("t5_busy_after", 32'(busy), 32'h0);
    chk("t5_pc_after", 32'(pc), 32'h3);

    // T6 reset while waiting on an operand, then a late ack
    rom[3] = 8'h05;
    rom[4] = 8'h66;
    rom[5] = 8'h77;
    lat = 4;
    cur_len = 3;
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    repeat (7) tick();
    chk("t6_opcode_pre", 32'(opcode), 32'h05);
    chk("t6_busy_pre", 32'(busy), 32'h1);
    fd0 = fd_cnt;
    ov0 = ov_cnt;
    rd0 = rd_cnt;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t6_pc_rst", 32'(pc), 32'h0);
    chk("t6_busy_rst", 32'(busy), 32'h0);
    chk("t6_opcode_rst", 32'(opcode), 32'h0);
    repeat (6) tick();
    chk("t6_fd_none", 32'(fd_cnt - fd0), 32'd0);
    chk("t6_ov_none", 32'(ov_cnt - ov0), 32'd0);
    chk("t6_rd_none", 32'(rd_cnt - rd0), 32'd0);
    chk("t6_pc_after", 32'(pc), 32'h0);
    chk("t6_busy_after", 32'(busy), 32'h0);
    chk("t6_ops_after", {16'h0, operand1, operand2}, 32'h0);

    chk("rd_overlap", 32'(viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
